// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: tracks a shadow copy of the EX/MEM/WB slots, detects
// load-use hazards, sequences stall/flush cycles and produces registered forward selects.
module ex_hazard_ctrl #(
  parameter int REG_DIR_WIDTH = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     id_valid,
  input  logic [REG_DIR_WIDTH-1:0] id_rs,
  input  logic [REG_DIR_WIDTH-1:0] id_rt,
  input  logic                     id_uses_rt,
  input  logic [REG_DIR_WIDTH-1:0] id_dst,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     ex_branch_taken,
  output logic [1:0]               Forward_A,
  output logic [1:0]               Forward_B,
  output logic                     pc_write,
  output logic                     ifid_write,
  output logic                     idex_bubble,
  output logic                     ifid_flush,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LD_STALL = 2'd1;
  localparam logic [1:0] ST_BR_FLUSH = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [REG_DIR_WIDTH-1:0] REG_ZERO = '0;

  logic [1:0]               r_state;
  logic                     r_ex_valid;
  logic [REG_DIR_WIDTH-1:0] r_ex_dst;
  logic                     r_ex_regwrite;
  logic                     r_ex_memread;
  logic                     r_mem_valid;
  logic [REG_DIR_WIDTH-1:0] r_mem_dst;
  logic                     r_mem_regwrite;
  logic                     r_wb_valid;
  logic [REG_DIR_WIDTH-1:0] r_wb_dst;
  logic                     r_wb_regwrite;
  logic [1:0]               r_fwd_a;
  logic [1:0]               r_fwd_b;
  logic [CNT_WIDTH-1:0]     r_stall_cnt;
  logic [CNT_WIDTH-1:0]     r_flush_cnt;

  logic       w_load_use;
  logic [1:0] w_next_state;
  logic       w_ex_fwd_ok;
  logic       w_mem_fwd_ok;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_unused_wb;

  // The WB slot mirrors the real pipeline but nothing here consumes it yet.
  assign w_unused_wb = &{1'b0, r_wb_valid, r_wb_dst, r_wb_regwrite};

  assign w_load_use = r_ex_valid & r_ex_memread & (r_ex_dst != REG_ZERO) & id_valid &
                      ((r_ex_dst == id_rs) | (id_uses_rt & (r_ex_dst == id_rt)));

  // A taken branch wins over a load-use hazard; both special states last one cycle.
  always_comb begin
    w_next_state = ST_RUN;
    if (r_state == ST_RUN) begin
      if (ex_branch_taken) begin
        w_next_state = ST_BR_FLUSH;
      end else if (w_load_use) begin
        w_next_state = ST_LD_STALL;
      end
    end
  end

  assign w_ex_fwd_ok  = r_ex_valid & r_ex_regwrite & (r_ex_dst != REG_ZERO);
  assign w_mem_fwd_ok = r_mem_valid & r_mem_regwrite & (r_mem_dst != REG_ZERO);

  always_comb begin
    w_fwd_a = 2'd0;
    w_fwd_b = 2'd0;
    if (w_ex_fwd_ok && (r_ex_dst == id_rs)) begin
      w_fwd_a = 2'd2;
    end else if (w_mem_fwd_ok && (r_mem_dst == id_rs)) begin
      w_fwd_a = 2'd1;
    end
    if (w_ex_fwd_ok && (r_ex_dst == id_rt)) begin
      w_fwd_b = 2'd2;
    end else if (w_mem_fwd_ok && (r_mem_dst == id_rt)) begin
      w_fwd_b = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_RUN;
      r_ex_valid     <= 1'b0;
      r_ex_dst       <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_dst      <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_dst       <= '0;
      r_wb_regwrite  <= 1'b0;
      r_fwd_a        <= 2'd0;
      r_fwd_b        <= 2'd0;
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
    end else begin
      r_state        <= w_next_state;
      r_wb_valid     <= r_mem_valid;
      r_wb_dst       <= r_mem_dst;
      r_wb_regwrite  <= r_mem_regwrite;
      r_mem_valid    <= r_ex_valid;
      r_mem_dst      <= r_ex_dst;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_next_state == ST_RUN) begin
        r_ex_valid    <= id_valid;
        r_ex_dst      <= id_dst;
        r_ex_regwrite <= id_regwrite;
        r_ex_memread  <= id_memread;
        r_fwd_a       <= w_fwd_a;
        r_fwd_b       <= w_fwd_b;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_fwd_a       <= 2'd0;
        r_fwd_b       <= 2'd0;
      end
      // Counters bump on entry so the count is visible during the stall/flush cycle itself.
      if ((w_next_state == ST_LD_STALL) && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if ((w_next_state == ST_BR_FLUSH) && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    case (r_state)
      ST_LD_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      ST_BR_FLUSH: begin
        idex_bubble = 1'b1;
        ifid_flush  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign Forward_A = r_fwd_a;
  assign Forward_B = r_fwd_b;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
